// File: rtl/pipe_stage_reg_pkg.sv
// Shared Y86 constants and default widths for the pipeline stage register.
package pipe_stage_reg_pkg;

  // Default widths used when the stage register is instantiated without overrides
  localparam int DATA_W_DEF = 64;
  localparam int N_VAL_DEF  = 3;
  localparam int ID_W_DEF   = 4;
  localparam int CNT_W_DEF  = 16;

  // Y86 instruction / register / status encodings
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] STAT_HLT  = 4'h2;
  localparam logic [3:0] STAT_ADR  = 4'h3;
  localparam logic [3:0] STAT_INS  = 4'h4;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear dominates; otherwise count up until every bit is set, then hold
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86 pipeline stage register (D/E/M/W) with stall, bubble,
// stall/bubble conflict flag and saturating event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_VAL  = N_VAL_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    bubble,
  input  logic [N_VAL*DATA_W-1:0] d_val,
  input  logic [ID_W-1:0]         d_icode,
  input  logic [ID_W-1:0]         d_ifun,
  input  logic [ID_W-1:0]         d_stat,
  input  logic [ID_W-1:0]         d_destE,
  input  logic [ID_W-1:0]         d_destM,
  output logic [N_VAL*DATA_W-1:0] E_val,
  output logic [ID_W-1:0]         E_icode,
  output logic [ID_W-1:0]         E_ifun,
  output logic [ID_W-1:0]         E_stat,
  output logic [ID_W-1:0]         E_destE,
  output logic [ID_W-1:0]         E_destM,
  output logic                    E_valid,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    conflict
);

  logic [N_VAL*DATA_W-1:0] r_val;
  logic [ID_W-1:0]         r_icode;
  logic [ID_W-1:0]         r_ifun;
  logic [ID_W-1:0]         r_stat;
  logic [ID_W-1:0]         r_destE;
  logic [ID_W-1:0]         r_destM;
  logic                    r_valid;
  logic                    r_conflict;

  // A bubble only takes effect when not stalled; a stall always counts
  logic w_bubble_inc;
  logic w_stall_inc;

  assign w_bubble_inc = bubble & ~stall;
  assign w_stall_inc  = stall;

  // Stage contents: reset and bubble both load a NOP with AOK status, stall holds,
  // otherwise capture the incoming fields unchanged (fields are opaque here)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= '0;
      r_icode <= ID_W'(ICODE_NOP);
      r_ifun  <= '0;
      r_stat  <= ID_W'(STAT_AOK);
      r_destE <= ID_W'(RNONE);
      r_destM <= ID_W'(RNONE);
      r_valid <= 1'b0;
    end else if (stall) begin
      r_val   <= r_val;
      r_icode <= r_icode;
      r_ifun  <= r_ifun;
      r_stat  <= r_stat;
      r_destE <= r_destE;
      r_destM <= r_destM;
      r_valid <= r_valid;
    end else if (bubble) begin
      r_val   <= '0;
      r_icode <= ID_W'(ICODE_NOP);
      r_ifun  <= '0;
      r_stat  <= ID_W'(STAT_AOK);
      r_destE <= ID_W'(RNONE);
      r_destM <= ID_W'(RNONE);
      r_valid <= 1'b0;
    end else begin
      r_val   <= d_val;
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_stat  <= d_stat;
      r_destE <= d_destE;
      r_destM <= d_destM;
      r_valid <= 1'b1;
    end
  end

  // Sticky flag for the illegal stall+bubble combination; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict <= 1'b0;
    end else if (stall && bubble) begin
      r_conflict <= 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_bubble_inc),
    .o_count (bubble_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  assign E_val    = r_val;
  assign E_icode  = r_icode;
  assign E_ifun   = r_ifun;
  assign E_stat   = r_stat;
  assign E_destE  = r_destE;
  assign E_destM  = r_destM;
  assign E_valid  = r_valid;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues the expected stage state
// for every cycle it drives; a monitor pops and compares one cycle later.
module tb_pipe_stage_reg;

  localparam int VW = 192;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          bubble;
  logic [VW-1:0] d_val;
  logic [3:0]    d_icode, d_ifun, d_stat, d_destE, d_destM;

  logic [VW-1:0] E_val;
  logic [3:0]    E_icode, E_ifun, E_stat, E_destE, E_destM;
  logic          E_valid;
  logic [15:0]   bubble_cnt, stall_cnt;
  logic          conflict;

  // Narrow-counter instance for saturation
  logic [VW-1:0] s_val;
  logic [3:0]    s_icode, s_ifun, s_stat, s_destE, s_destM;
  logic          s_valid;
  logic [1:0]    s_bubble_cnt, s_stall_cnt;
  logic          s_conflict;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .bubble     (bubble),
    .d_val      (d_val),
    .d_icode    (d_icode),
    .d_ifun     (d_ifun),
    .d_stat     (d_stat),
    .d_destE    (d_destE),
    .d_destM    (d_destM),
    .E_val      (E_val),
    .E_icode    (E_icode),
    .E_ifun     (E_ifun),
    .E_stat     (E_stat),
    .E_destE    (E_destE),
    .E_destM    (E_destM),
    .E_valid    (E_valid),
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt),
    .conflict   (conflict)
  );

  pipe_stage_reg #(
    .CNT_W (2)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .bubble     (bubble),
    .d_val      (d_val),
    .d_icode    (d_icode),
    .d_ifun     (d_ifun),
    .d_stat     (d_stat),
    .d_destE    (d_destE),
    .d_destM    (d_destM),
    .E_val      (s_val),
    .E_icode    (s_icode),
    .E_ifun     (s_ifun),
    .E_stat     (s_stat),
    .E_destE    (s_destE),
    .E_destM    (s_destM),
    .E_valid    (s_valid),
    .bubble_cnt (s_bubble_cnt),
    .stall_cnt  (s_stall_cnt),
    .conflict   (s_conflict)
  );

  typedef struct {
    string         name;
    logic [VW-1:0] val;
    logic [3:0]    icode, ifun, stat, destE, destM;
    logic          valid;
    logic [15:0]   bcnt, scnt;
    logic          conf;
    logic [1:0]    sat_scnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [VW-1:0] V1 = {64'h10, 64'h5, 64'h7};
  localparam logic [VW-1:0] V2 = {64'hCAFE, 64'hBEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [VW-1:0] V3 = {64'h3, 64'h2, 64'h1};
  localparam logic [VW-1:0] V4 = {64'hAAAA, 64'h5555, 64'h1234_5678_9ABC_DEF0};
  localparam logic [VW-1:0] VJ = {64'hDEAD, 64'hDEAD, 64'hDEAD};

  task automatic chk(input string name, input string fld,
                     input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", name, fld, act, exp);
    end
  endtask

  // Monitor: the stage updates every clock, so every cycle with a queued entry is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "E_val",      E_val,      e.val);
        chk(e.name, "E_icode",    {188'd0, E_icode}, {188'd0, e.icode});
        chk(e.name, "E_ifun",     {188'd0, E_ifun},  {188'd0, e.ifun});
        chk(e.name, "E_stat",     {188'd0, E_stat},  {188'd0, e.stat});
        chk(e.name, "E_destE",    {188'd0, E_destE}, {188'd0, e.destE});
        chk(e.name, "E_destM",    {188'd0, E_destM}, {188'd0, e.destM});
        chk(e.name, "E_valid",    {191'd0, E_valid}, {191'd0, e.valid});
        chk(e.name, "bubble_cnt", {176'd0, bubble_cnt}, {176'd0, e.bcnt});
        chk(e.name, "stall_cnt",  {176'd0, stall_cnt},  {176'd0, e.scnt});
        chk(e.name, "conflict",   {191'd0, conflict},   {191'd0, e.conf});
        chk(e.name, "sat_stall_cnt", {190'd0, s_stall_cnt}, {190'd0, e.sat_scnt});
        $display("cycle %-12s icode=%0h stat=%0h valid=%0b bcnt=%0d scnt=%0d conf=%0b sat=%0d",
                 e.name, E_icode, E_stat, E_valid, bubble_cnt, stall_cnt, conflict, s_stall_cnt);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] st,
                       input logic [3:0] de, input logic [3:0] dm, input logic [VW-1:0] v);
    @(negedge clk);
    rst = r; stall = s; bubble = b;
    d_icode = ic; d_ifun = fn; d_stat = st; d_destE = de; d_destM = dm; d_val = v;
  endtask

  task automatic expect_state(input string nm, input logic [VW-1:0] v,
                              input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] st,
                              input logic [3:0] de, input logic [3:0] dm, input logic vld,
                              input logic [15:0] bc, input logic [15:0] sc, input logic cf,
                              input logic [1:0] ssc);
    exp_t e;
    e.name = nm; e.val = v; e.icode = ic; e.ifun = fn; e.stat = st;
    e.destE = de; e.destM = dm; e.valid = vld; e.bcnt = bc; e.scnt = sc;
    e.conf = cf; e.sat_scnt = ssc;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    d_icode = '0; d_ifun = '0; d_stat = '0; d_destE = '0; d_destM = '0; d_val = '0;

    // Reset to NOP bubble
    drive(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, '0);
    expect_state("reset",   '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0);
    // Load one instruction
    drive(0, 0, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("load1",   V1, 6, 0, 1, 4'h3, 4'hF, 1, 0, 0, 0, 0);
    // Stall three cycles with changing inputs
    drive(0, 1, 0, 4'h2, 4'h1, 4'h3, 4'h4, 4'h5, VJ);
    expect_state("stall1",  V1, 6, 0, 1, 4'h3, 4'hF, 1, 0, 1, 0, 1);
    drive(0, 1, 0, 4'h9, 4'h2, 4'h4, 4'h0, 4'h1, V2);
    expect_state("stall2",  V1, 6, 0, 1, 4'h3, 4'hF, 1, 0, 2, 0, 2);
    drive(0, 1, 0, 4'hB, 4'h7, 4'h2, 4'h6, 4'h6, V3);
    expect_state("stall3",  V1, 6, 0, 1, 4'h3, 4'hF, 1, 0, 3, 0, 3);
    // Bubble with an exception status on the input: must not propagate
    drive(0, 0, 1, 4'h6, 4'h1, 4'h4, 4'h2, 4'h2, VJ);
    expect_state("bubble1", '0, 1, 0, 1, 4'hF, 4'hF, 0, 1, 3, 0, 3);
    // Load passes status through unchanged
    drive(0, 0, 0, 4'h3, 4'h5, 4'h4, 4'h2, 4'h7, V2);
    expect_state("load2",   V2, 3, 5, 4, 4'h2, 4'h7, 1, 1, 3, 0, 3);
    // Stall+bubble: hold, flag conflict, count stall only
    drive(0, 1, 1, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1, VJ);
    expect_state("conflict",V2, 3, 5, 4, 4'h2, 4'h7, 1, 1, 4, 1, 3);
    // Conflict stays set after both drop
    drive(0, 0, 0, 4'h5, 4'h0, 4'h1, 4'hF, 4'h4, V3);
    expect_state("load3",   V3, 5, 0, 1, 4'hF, 4'h4, 1, 1, 4, 1, 3);
    drive(0, 0, 1, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, V4);
    expect_state("bubble2", '0, 1, 0, 1, 4'hF, 4'hF, 0, 2, 4, 1, 3);
    drive(0, 0, 0, 4'hA, 4'h2, 4'h2, 4'h5, 4'h6, V4);
    expect_state("load4",   V4, 10, 2, 2, 4'h5, 4'h6, 1, 2, 4, 1, 3);
    drive(0, 1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, VJ);
    expect_state("stall4",  V4, 10, 2, 2, 4'h5, 4'h6, 1, 2, 5, 1, 3);
    // Reset mid-stall with bubble: discards held contents, clears everything
    drive(1, 1, 1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, VJ);
    expect_state("rst_stall", '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0);
    // Saturation run on the narrow counter: 1,2,3,3,3
    drive(0, 1, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("sat1",    '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 1);
    drive(0, 1, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("sat2",    '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 2, 0, 2);
    drive(0, 1, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("sat3",    '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 3, 0, 3);
    drive(0, 1, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("sat4",    '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 4, 0, 3);
    drive(0, 1, 0, 4'h6, 4'h0, 4'h1, 4'h3, 4'hF, V1);
    expect_state("sat5",    '0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 5, 0, 3);
    // Normal load after the stall run
    drive(0, 0, 0, 4'h7, 4'h1, 4'h2, 4'h0, 4'h0, V4);
    expect_state("load5",   V4, 7, 1, 2, 4'h0, 4'h0, 1, 0, 5, 0, 3);
    drive(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'hF, 4'hF, '0);
    expect_state("load6",   '0, 0, 0, 1, 4'hF, 4'hF, 1, 0, 5, 0, 3);

    // Drain the scoreboard with a bounded wait
    begin
      int waited;
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      #2;
      if (q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain actual=%0d entries left expected=0", q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
